// File: rtl/di_fifo_term.sv
// Host-facing FIFO terminal: 16-bit words written on the data port are buffered in a
// synchronous-read RAM and returned first-word-fall-through on a later read transfer.
module di_fifo_term #(
  parameter logic [15:0] TERM_ADDR = 16'h0010,
  parameter int unsigned ADDR_W    = 8
) (
  input  logic              ifclk,
  input  logic              resetb,
  input  logic [15:0]       di_term_addr,
  input  logic [31:0]       di_reg_addr,
  input  logic              di_read_mode,
  input  logic              di_write_mode,
  input  logic              di_read,
  input  logic              di_write,
  input  logic [15:0]       di_reg_datai,
  output logic [15:0]       di_reg_datao,
  output logic              di_read_rdy,
  output logic              di_write_rdy,
  output logic [15:0]       di_transfer_status,
  output logic [ADDR_W:0]   fifo_count
);

  localparam int unsigned DEPTH   = 2 ** ADDR_W;
  localparam int unsigned PTR_W   = ADDR_W + 1;
  localparam logic [31:0] REG_DATA   = 32'd0;
  localparam logic [31:0] REG_COUNT  = 32'd1;
  localparam logic [31:0] REG_STATUS = 32'd2;
  localparam logic [15:0] ERR_OVF    = 16'h0001;
  localparam logic [15:0] ERR_UNF    = 16'h0002;
  localparam logic [15:0] BAD_REG    = 16'hDEAD;

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_WR   = 2'd1,
    S_RD   = 2'd2
  } state_t;

  state_t             r_state;
  state_t             w_state_nxt;
  logic               w_enter;

  logic [15:0]        r_mem [DEPTH];
  logic [15:0]        r_ram_q;
  logic               r_hold_vld;
  logic [PTR_W-1:0]   r_wr_ptr;
  logic [PTR_W-1:0]   r_rd_ptr;
  logic [PTR_W-1:0]   r_count;
  logic [15:0]        r_err;
  logic               r_ovf_seen;
  logic               r_unf_seen;

  logic               w_sel;
  logic               w_in_wr;
  logic               w_in_rd;
  logic               w_reg_data;
  logic               w_reg_count;
  logic               w_reg_status;
  logic               w_full;
  logic               w_ram_has;
  logic               w_push;
  logic               w_ovf;
  logic               w_flush;
  logic               w_pop;
  logic               w_unf;
  logic               w_fetch;

  // Address decode and per-cycle transfer events
  always_comb begin
    w_sel        = (di_term_addr == TERM_ADDR);
    w_in_wr      = w_sel && (r_state == S_WR);
    w_in_rd      = w_sel && (r_state == S_RD);
    w_reg_data   = (di_reg_addr == REG_DATA);
    w_reg_count  = (di_reg_addr == REG_COUNT);
    w_reg_status = (di_reg_addr == REG_STATUS);
    w_full       = (r_count == PTR_W'(DEPTH));
    w_ram_has    = (r_wr_ptr != r_rd_ptr);
    w_push       = w_in_wr && w_reg_data && di_write && !w_full;
    w_ovf        = w_in_wr && w_reg_data && di_write && w_full;
    w_flush      = w_in_wr && w_reg_status && di_write && di_reg_datai[0];
    w_pop        = w_in_rd && w_reg_data && di_read && r_hold_vld;
    w_unf        = w_in_rd && w_reg_data && di_read && !r_hold_vld;
    // Refill the holding register as it empties so reads stream at one word per cycle
    w_fetch      = !w_flush && w_ram_has && (!r_hold_vld || w_pop);
  end

  // Transfer-mode state register
  always_ff @(posedge ifclk or negedge resetb) begin
    if (!resetb) begin
      r_state <= S_IDLE;
    end else begin
      r_state <= w_state_nxt;
    end
  end

  // Next-state logic; mode changes are ignored while another terminal is addressed
  always_comb begin
    w_state_nxt = r_state;
    w_enter     = 1'b0;
    case (r_state)
      S_IDLE: begin
        if (w_sel && di_write_mode) begin
          w_state_nxt = S_WR;
          w_enter     = 1'b1;
        end else if (w_sel && di_read_mode) begin
          w_state_nxt = S_RD;
          w_enter     = 1'b1;
        end
      end
      S_WR: begin
        if (w_sel && !di_write_mode) w_state_nxt = S_IDLE;
      end
      S_RD: begin
        if (w_sel && !di_read_mode) w_state_nxt = S_IDLE;
      end
      default: w_state_nxt = S_IDLE;
    endcase
  end

  // Buffer storage: registered read port keeps it mappable onto block RAM
  always_ff @(posedge ifclk) begin
    if (w_push) r_mem[r_wr_ptr[ADDR_W-1:0]] <= di_reg_datai;
    if (w_fetch) r_ram_q <= r_mem[r_rd_ptr[ADDR_W-1:0]];
  end

  // Pointers, fill level and holding-register valid flag
  always_ff @(posedge ifclk or negedge resetb) begin
    if (!resetb) begin
      r_wr_ptr   <= '0;
      r_rd_ptr   <= '0;
      r_count    <= '0;
      r_hold_vld <= 1'b0;
    end else if (w_flush) begin
      r_wr_ptr   <= '0;
      r_rd_ptr   <= '0;
      r_count    <= '0;
      r_hold_vld <= 1'b0;
    end else begin
      if (w_push) r_wr_ptr <= r_wr_ptr + PTR_W'(1);
      if (w_fetch) r_rd_ptr <= r_rd_ptr + PTR_W'(1);
      if (w_fetch) begin
        r_hold_vld <= 1'b1;
      end else if (w_pop) begin
        r_hold_vld <= 1'b0;
      end
      case ({w_push, w_pop})
        2'b10:   r_count <= r_count + PTR_W'(1);
        2'b01:   r_count <= r_count - PTR_W'(1);
        default: r_count <= r_count;
      endcase
    end
  end

  // Sticky error code keeps the first error of a transfer; flags record every kind seen
  always_ff @(posedge ifclk or negedge resetb) begin
    if (!resetb) begin
      r_err      <= '0;
      r_ovf_seen <= 1'b0;
      r_unf_seen <= 1'b0;
    end else if (w_enter) begin
      r_err      <= '0;
      r_ovf_seen <= 1'b0;
      r_unf_seen <= 1'b0;
    end else begin
      if (w_ovf) begin
        r_ovf_seen <= 1'b1;
        if (r_err == 16'h0000) r_err <= ERR_OVF;
      end
      if (w_unf) begin
        r_unf_seen <= 1'b1;
        if (r_err == 16'h0000 && !w_ovf) r_err <= ERR_UNF;
      end
    end
  end

  // Host-visible read data, ready flags and status
  always_comb begin
    di_reg_datao       = '0;
    di_read_rdy        = 1'b0;
    di_write_rdy       = 1'b0;
    di_transfer_status = '0;
    fifo_count         = '0;
    if (w_sel) begin
      di_transfer_status = r_err;
      fifo_count         = r_count;
    end
    if (w_in_wr) begin
      di_write_rdy = w_reg_data ? !w_full : 1'b1;
    end
    if (w_in_rd) begin
      if (w_reg_data) begin
        di_read_rdy  = r_hold_vld;
        di_reg_datao = r_hold_vld ? r_ram_q : 16'h0000;
      end else if (w_reg_count) begin
        di_read_rdy  = 1'b1;
        di_reg_datao = 16'(r_count);
      end else if (w_reg_status) begin
        di_read_rdy  = 1'b1;
        di_reg_datao = {14'b0, r_ovf_seen, r_unf_seen};
      end else begin
        di_read_rdy  = 1'b1;
        di_reg_datao = BAD_REG;
      end
    end
  end

endmodule

// File: tb/tb_di_fifo_term.sv
// Bench for di_fifo_term: vector table, directed corner sequences and a randomized
// run checked against a queue-based model of the terminal.
module tb_di_fifo_term;

  localparam logic [15:0] T = 16'h0010;
  localparam logic [15:0] A = 16'h0011;

  logic        ifclk;
  logic        resetb;
  logic [15:0] di_term_addr;
  logic [31:0] di_reg_addr;
  logic        di_read_mode, di_write_mode, di_read, di_write;
  logic [15:0] di_reg_datai;
  logic [15:0] di_reg_datao;
  logic        di_read_rdy, di_write_rdy;
  logic [15:0] di_transfer_status;
  logic [8:0]  fifo_count;

  di_fifo_term #(.TERM_ADDR(T), .ADDR_W(8)) dut (
    .ifclk(ifclk), .resetb(resetb), .di_term_addr(di_term_addr), .di_reg_addr(di_reg_addr),
    .di_read_mode(di_read_mode), .di_write_mode(di_write_mode), .di_read(di_read),
    .di_write(di_write), .di_reg_datai(di_reg_datai), .di_reg_datao(di_reg_datao),
    .di_read_rdy(di_read_rdy), .di_write_rdy(di_write_rdy),
    .di_transfer_status(di_transfer_status), .fifo_count(fifo_count)
  );

  initial ifclk = 1'b0;
  always #5 ifclk = ~ifclk;

  int n_cmp = 0;
  int n_bad = 0;

  typedef struct {
    logic [15:0] t;
    logic [31:0] ra;
    logic        rm, wm, rd, wr;
    logic [15:0] d;
    logic        ew, er;
    logic [15:0] ed, es;
    logic [8:0]  ec;
  } vec_t;

  vec_t vt[$];

  // Reference model state: buffer contents as a queue plus transfer mode and errors
  logic [15:0] mq[$];
  int          m_st;
  logic [15:0] m_err;
  logic        m_ovf, m_unf;

  function automatic vec_t mk(input logic [15:0] t, input logic [31:0] ra,
                              input logic rm, wm, rd, wr, input logic [15:0] d,
                              input logic ew, er, input logic [15:0] ed, es,
                              input logic [8:0] ec);
    vec_t v;
    v.t = t; v.ra = ra; v.rm = rm; v.wm = wm; v.rd = rd; v.wr = wr; v.d = d;
    v.ew = ew; v.er = er; v.ed = ed; v.es = es; v.ec = ec;
    return v;
  endfunction

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: actual=%0h required=%0h", nm, act, exp);
    end
  endtask

  task automatic chk_all(input string nm, input logic ew, er, input logic [15:0] ed, es,
                         input logic [8:0] ec);
    chk({nm, ".wrdy"},   32'(di_write_rdy),       32'(ew));
    chk({nm, ".rrdy"},   32'(di_read_rdy),        32'(er));
    chk({nm, ".datao"},  32'(di_reg_datao),       32'(ed));
    chk({nm, ".status"}, 32'(di_transfer_status), 32'(es));
    chk({nm, ".count"},  32'(fifo_count),         32'(ec));
  endtask

  task automatic drv(input logic [15:0] t, input logic [31:0] ra, input logic rm, wm, rd, wr,
                     input logic [15:0] d);
    di_term_addr = t; di_reg_addr = ra; di_read_mode = rm; di_write_mode = wm;
    di_read = rd; di_write = wr; di_reg_datai = d;
  endtask

  task automatic cyc();
    @(posedge ifclk);
    #1;
  endtask

  task automatic enter(input logic wr_mode);
    drv(T, 32'd0, !wr_mode, wr_mode, 1'b0, 1'b0, 16'h0);
    cyc();
  endtask

  task automatic leave();
    drv(T, 32'd0, 1'b0, 1'b0, 1'b0, 1'b0, 16'h0);
    cyc();
  endtask

  task automatic do_reset();
    resetb = 1'b0;
    drv(T, 32'd0, 1'b0, 1'b0, 1'b0, 1'b0, 16'h0);
    cyc();
    cyc();
    resetb = 1'b1;
  endtask

  task automatic write_words(input int n, input int base);
    for (int i = 0; i < n; i++) begin
      drv(T, 32'd0, 1'b0, 1'b1, 1'b0, 1'b1, 16'(base + i));
      cyc();
    end
  endtask

  task automatic mdl_expect(output logic ew, er, output logic [15:0] ed, es,
                            output logic [8:0] ec);
    ew = 1'b0; er = 1'b0; ed = '0; es = '0; ec = '0;
    if (di_term_addr == T) begin
      es = m_err;
      ec = 9'(mq.size());
      if (m_st == 1) begin
        ew = (di_reg_addr != 32'd0) || (mq.size() < 256);
      end else if (m_st == 2) begin
        if (di_reg_addr == 32'd0) begin
          er = (mq.size() > 0);
          ed = er ? mq[0] : 16'h0000;
        end else if (di_reg_addr == 32'd1) begin
          er = 1'b1; ed = 16'(mq.size());
        end else if (di_reg_addr == 32'd2) begin
          er = 1'b1; ed = {14'b0, m_ovf, m_unf};
        end else begin
          er = 1'b1; ed = 16'hDEAD;
        end
      end
    end
  endtask

  task automatic mdl_step();
    logic ovf, unf;
    ovf = 1'b0; unf = 1'b0;
    if (di_term_addr != T) return;
    if (m_st == 1) begin
      if (di_reg_addr == 32'd0 && di_write) begin
        if (mq.size() < 256) mq.push_back(di_reg_datai);
        else ovf = 1'b1;
      end
      if (di_reg_addr == 32'd2 && di_write && di_reg_datai[0]) mq.delete();
    end else if (m_st == 2) begin
      if (di_reg_addr == 32'd0 && di_read) begin
        if (mq.size() > 0) void'(mq.pop_front());
        else unf = 1'b1;
      end
    end
    if (ovf) begin m_ovf = 1'b1; if (m_err == 16'h0) m_err = 16'h0001; end
    if (unf) begin m_unf = 1'b1; if (m_err == 16'h0) m_err = 16'h0002; end
    case (m_st)
      0: begin
        if (di_write_mode || di_read_mode) begin
          m_st = di_write_mode ? 1 : 2;
          m_err = '0; m_ovf = 1'b0; m_unf = 1'b0;
        end
      end
      1: if (!di_write_mode) m_st = 0;
      default: if (!di_read_mode) m_st = 0;
    endcase
  endtask

  task automatic rstep();
    logic ew, er;
    logic [15:0] ed, es;
    logic [8:0] ec;
    @(negedge ifclk);
    mdl_expect(ew, er, ed, es, ec);
    chk_all("rnd", ew, er, ed, es, ec);
    mdl_step();
    cyc();
  endtask

  initial begin
    int kind, len, rsel;
    logic [15:0] t;
    logic [31:0] ra;
    logic rm, wm, rd, wr;

    // Outputs while reset is held
    resetb = 1'b0;
    drv(T, 32'd0, 1'b1, 1'b1, 1'b1, 1'b1, 16'h1234);
    cyc();
    cyc();
    chk_all("in_reset", 1'b0, 1'b0, 16'h0, 16'h0, 9'd0);
    do_reset();

    // One record per cycle: inputs, then the outputs expected before the clock edge
    vt.push_back(mk(T, 32'd0, 0, 0, 0, 0, 16'h0,    0, 0, 16'h0,    16'h0, 9'd0));
    vt.push_back(mk(T, 32'd0, 0, 1, 0, 0, 16'h0,    0, 0, 16'h0,    16'h0, 9'd0));
    vt.push_back(mk(T, 32'd0, 0, 1, 0, 1, 16'd1,    1, 0, 16'h0,    16'h0, 9'd0));
    vt.push_back(mk(T, 32'd0, 0, 1, 0, 1, 16'd2,    1, 0, 16'h0,    16'h0, 9'd1));
    vt.push_back(mk(T, 32'd0, 0, 1, 0, 1, 16'd3,    1, 0, 16'h0,    16'h0, 9'd2));
    vt.push_back(mk(T, 32'd0, 0, 1, 0, 1, 16'd4,    1, 0, 16'h0,    16'h0, 9'd3));
    vt.push_back(mk(T, 32'd0, 0, 0, 0, 0, 16'h0,    1, 0, 16'h0,    16'h0, 9'd4));
    vt.push_back(mk(T, 32'd0, 1, 0, 0, 0, 16'h0,    0, 0, 16'h0,    16'h0, 9'd4));
    vt.push_back(mk(T, 32'd0, 1, 0, 1, 0, 16'h0,    0, 1, 16'd1,    16'h0, 9'd4));
    vt.push_back(mk(T, 32'd0, 1, 0, 1, 0, 16'h0,    0, 1, 16'd2,    16'h0, 9'd3));
    vt.push_back(mk(T, 32'd0, 1, 0, 1, 0, 16'h0,    0, 1, 16'd3,    16'h0, 9'd2));
    vt.push_back(mk(T, 32'd0, 1, 0, 1, 0, 16'h0,    0, 1, 16'd4,    16'h0, 9'd1));
    vt.push_back(mk(T, 32'd0, 1, 0, 0, 0, 16'h0,    0, 0, 16'h0,    16'h0, 9'd0));
    vt.push_back(mk(T, 32'd2, 1, 0, 0, 0, 16'h0,    0, 1, 16'h0,    16'h0, 9'd0));
    vt.push_back(mk(T, 32'd0, 1, 0, 1, 0, 16'h0,    0, 0, 16'h0,    16'h0, 9'd0));
    vt.push_back(mk(T, 32'd0, 1, 0, 0, 0, 16'h0,    0, 0, 16'h0,    16'h2, 9'd0));
    vt.push_back(mk(T, 32'd2, 1, 0, 0, 0, 16'h0,    0, 1, 16'h1,    16'h2, 9'd0));
    vt.push_back(mk(T, 32'd7, 1, 0, 0, 0, 16'h0,    0, 1, 16'hDEAD, 16'h2, 9'd0));
    vt.push_back(mk(T, 32'd1, 1, 0, 0, 0, 16'h0,    0, 1, 16'h0,    16'h2, 9'd0));
    vt.push_back(mk(T, 32'd0, 0, 0, 0, 0, 16'h0,    0, 0, 16'h0,    16'h2, 9'd0));
    vt.push_back(mk(T, 32'd0, 0, 0, 0, 0, 16'h0,    0, 0, 16'h0,    16'h2, 9'd0));
    vt.push_back(mk(T, 32'd0, 0, 1, 0, 0, 16'h0,    0, 0, 16'h0,    16'h2, 9'd0));
    vt.push_back(mk(T, 32'd0, 0, 1, 0, 0, 16'h0,    1, 0, 16'h0,    16'h0, 9'd0));
    vt.push_back(mk(T, 32'd0, 0, 1, 0, 1, 16'hABCD, 1, 0, 16'h0,    16'h0, 9'd0));
    vt.push_back(mk(A, 32'd0, 0, 1, 0, 1, 16'd5,    0, 0, 16'h0,    16'h0, 9'd0));
    vt.push_back(mk(A, 32'd0, 1, 0, 1, 0, 16'h0,    0, 0, 16'h0,    16'h0, 9'd0));
    vt.push_back(mk(T, 32'd0, 0, 1, 0, 0, 16'h0,    1, 0, 16'h0,    16'h0, 9'd1));
    vt.push_back(mk(T, 32'd0, 0, 0, 0, 0, 16'h0,    1, 0, 16'h0,    16'h0, 9'd1));
    vt.push_back(mk(T, 32'd0, 1, 0, 0, 0, 16'h0,    0, 0, 16'h0,    16'h0, 9'd1));
    vt.push_back(mk(T, 32'd0, 1, 0, 1, 0, 16'h0,    0, 1, 16'hABCD, 16'h0, 9'd1));
    vt.push_back(mk(T, 32'd0, 1, 0, 0, 0, 16'h0,    0, 0, 16'h0,    16'h0, 9'd0));
    vt.push_back(mk(T, 32'd0, 0, 0, 0, 0, 16'h0,    0, 0, 16'h0,    16'h0, 9'd0));
    vt.push_back(mk(T, 32'd0, 0, 0, 0, 0, 16'h0,    0, 0, 16'h0,    16'h0, 9'd0));
    for (int i = 0; i < vt.size(); i++) begin
      drv(vt[i].t, vt[i].ra, vt[i].rm, vt[i].wm, vt[i].rd, vt[i].wr, vt[i].d);
      @(negedge ifclk);
      chk_all($sformatf("vec%0d", i), vt[i].ew, vt[i].er, vt[i].ed, vt[i].es, vt[i].ec);
      cyc();
    end

    // Overflow: 257 writes, 256 kept, then read back in order with no gaps
    do_reset();
    enter(1'b1);
    for (int i = 0; i < 257; i++) begin
      drv(T, 32'd0, 1'b0, 1'b1, 1'b0, 1'b1, 16'(i));
      @(negedge ifclk);
      if (i < 256) begin
        chk("ovf.wrdy", 32'(di_write_rdy), 32'd1);
      end else begin
        chk("ovf.wrdy_full", 32'(di_write_rdy), 32'd0);
        chk("ovf.count_full", 32'(fifo_count), 32'd256);
      end
      cyc();
    end
    drv(T, 32'd0, 1'b0, 1'b1, 1'b0, 1'b0, 16'h0);
    @(negedge ifclk);
    chk("ovf.status", 32'(di_transfer_status), 32'h0001);
    chk("ovf.count", 32'(fifo_count), 32'd256);
    leave();
    enter(1'b0);
    for (int i = 0; i < 256; i++) begin
      drv(T, 32'd0, 1'b1, 1'b0, 1'b1, 1'b0, 16'h0);
      @(negedge ifclk);
      chk("ovf.rd_rdy", 32'(di_read_rdy), 32'd1);
      chk("ovf.rd_data", 32'(di_reg_datao), 32'(i));
      cyc();
    end
    drv(T, 32'd0, 1'b1, 1'b0, 1'b0, 1'b0, 16'h0);
    @(negedge ifclk);
    chk_all("ovf.drained", 1'b0, 1'b0, 16'h0, 16'h0, 9'd0);
    leave();

    // Single word latency, then an 8-word streaming read
    enter(1'b1);
    write_words(1, 16'h55AA);
    leave();
    enter(1'b0);
    drv(T, 32'd0, 1'b1, 1'b0, 1'b0, 1'b0, 16'h0);
    @(negedge ifclk);
    chk("lat.rrdy", 32'(di_read_rdy), 32'd1);
    chk("lat.data", 32'(di_reg_datao), 32'h55AA);
    drv(T, 32'd0, 1'b1, 1'b0, 1'b1, 1'b0, 16'h0);
    cyc();
    leave();
    enter(1'b1);
    write_words(8, 100);
    leave();
    enter(1'b0);
    for (int i = 0; i < 8; i++) begin
      drv(T, 32'd0, 1'b1, 1'b0, 1'b1, 1'b0, 16'h0);
      @(negedge ifclk);
      chk("burst.rrdy", 32'(di_read_rdy), 32'd1);
      chk("burst.data", 32'(di_reg_datao), 32'(100 + i));
      cyc();
    end
    drv(T, 32'd0, 1'b1, 1'b0, 1'b0, 1'b0, 16'h0);
    @(negedge ifclk);
    chk("burst.empty", 32'(di_read_rdy), 32'd0);
    leave();

    // Flush through the status register
    enter(1'b1);
    write_words(10, 16'h0300);
    drv(T, 32'd0, 1'b0, 1'b1, 1'b0, 1'b0, 16'h0);
    @(negedge ifclk);
    chk("flush.count10", 32'(fifo_count), 32'd10);
    drv(T, 32'd2, 1'b0, 1'b1, 1'b0, 1'b1, 16'h0001);
    @(negedge ifclk);
    chk("flush.wrdy", 32'(di_write_rdy), 32'd1);
    cyc();
    drv(T, 32'd0, 1'b0, 1'b1, 1'b0, 1'b0, 16'h0);
    @(negedge ifclk);
    chk("flush.count0", 32'(fifo_count), 32'd0);
    leave();
    enter(1'b0);
    drv(T, 32'd1, 1'b1, 1'b0, 1'b0, 1'b0, 16'h0);
    @(negedge ifclk);
    chk("flush.reg1_rdy", 32'(di_read_rdy), 32'd1);
    chk("flush.reg1", 32'(di_reg_datao), 32'd0);
    drv(T, 32'd0, 1'b1, 1'b0, 1'b0, 1'b0, 16'h0);
    @(negedge ifclk);
    chk("flush.rrdy", 32'(di_read_rdy), 32'd0);
    leave();

    // Reset asserted in the middle of a read transfer
    enter(1'b1);
    write_words(5, 0);
    leave();
    enter(1'b0);
    for (int i = 0; i < 2; i++) begin
      drv(T, 32'd0, 1'b1, 1'b0, 1'b1, 1'b0, 16'h0);
      cyc();
    end
    drv(T, 32'd0, 1'b1, 1'b0, 1'b0, 1'b0, 16'h0);
    @(negedge ifclk);
    chk("rst.pre_data", 32'(di_reg_datao), 32'd2);
    chk("rst.pre_count", 32'(fifo_count), 32'd3);
    resetb = 1'b0;
    #1;
    chk_all("rst.mid", 1'b0, 1'b0, 16'h0, 16'h0, 9'd0);
    drv(T, 32'd0, 1'b0, 1'b0, 1'b0, 1'b0, 16'h0);
    cyc();
    cyc();
    resetb = 1'b1;
    @(negedge ifclk);
    chk_all("rst.after", 1'b0, 1'b0, 16'h0, 16'h0, 9'd0);
    cyc();
    enter(1'b0);
    drv(T, 32'd0, 1'b1, 1'b0, 1'b0, 1'b0, 16'h0);
    @(negedge ifclk);
    chk("rst.rrdy", 32'(di_read_rdy), 32'd0);
    chk("rst.count", 32'(fifo_count), 32'd0);
    leave();

    // Randomized transfer sessions against the queue model
    do_reset();
    mq.delete();
    m_st = 0; m_err = '0; m_ovf = 1'b0; m_unf = 1'b0;
    for (int s = 0; s < 250; s++) begin
      kind = $urandom_range(0, 2);
      len  = $urandom_range(2, 20);
      for (int c = 0; c < len; c++) begin
        rsel = $urandom_range(0, 15);
        if (rsel < 11)       ra = 32'd0;
        else if (rsel == 11) ra = 32'd1;
        else if (rsel == 12) ra = 32'd2;
        else                 ra = 32'($urandom_range(3, 40));
        if (kind == 0) begin
          t = T; wm = 1'b1; rm = ($urandom_range(0, 7) == 0);
          wr = ($urandom_range(0, 3) != 0); rd = 1'($urandom_range(0, 1));
          if (ra == 32'd2 && $urandom_range(0, 3) != 0) ra = 32'd0;
        end else if (kind == 1) begin
          t = T; wm = 1'b0; rm = 1'b1;
          rd = ($urandom_range(0, 3) != 0); wr = 1'($urandom_range(0, 1));
        end else begin
          t = T ^ 16'(1 << $urandom_range(0, 15));
          wm = 1'($urandom_range(0, 1)); rm = 1'($urandom_range(0, 1));
          wr = 1'($urandom_range(0, 1)); rd = 1'($urandom_range(0, 1));
        end
        drv(t, ra, rm, wm, rd, wr, 16'($urandom));
        rstep();
      end
      drv(T, 32'd0, 1'b0, 1'b0, 1'b0, 1'b0, 16'h0);
      rstep();
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
